uart_digit_sequencer: RTL and testbench

Sits between the UART receiver byte stream and the 3-bit seven-segment decoder on the uart_all board design. Accepts received bytes over a valid/ready handshake and filters ASCII digits '0'..'7'. Queues them in a small FIFO and presents each one on digit_bcd for a fixed hold time, so a burst of characters is readable on the display. Also flags invalid characters and dropped bytes.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/digit_fifo.sv | 51 +++++
 rtl/uart_digit_sequencer.sv | 106 ++++++++++
 tb/tb_uart_digit_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared ASCII constants, FSM encoding and byte classifier for the UART digit path.
package uart_pkg;

  localparam logic [7:0] ASCII_DIGIT_LO = 8'h30;
  localparam logic [7:0] ASCII_DIGIT_HI = 8'h37;
  localparam logic [7:0] ASCII_CLR_U    = 8'h43;
  localparam logic [7:0] ASCII_CLR_L    = 8'h63;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_CR       = 8'h0D;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } seq_state_e;

  typedef enum logic [1:0] {
    CLS_DIGIT = 2'd0,
    CLS_CLEAR = 2'd1,
    CLS_EOL   = 2'd2,
    CLS_BAD   = 2'd3
  } char_class_e;

  // Line endings are swallowed quietly; anything not otherwise known is bad.
  function automatic char_class_e classify(input logic [7:0] b);
    char_class_e c;
    if (b >= ASCII_DIGIT_LO && b <= ASCII_DIGIT_HI)  c = CLS_DIGIT;
    else if (b == ASCII_CLR_U || b == ASCII_CLR_L)   c = CLS_CLEAR;
    else if (b == ASCII_LF || b == ASCII_CR)         c = CLS_EOL;
    else                                             c = CLS_BAD;
    return c;
  endfunction

endpackage

// File: rtl/digit_fifo.sv
// Small synchronous FIFO; push, pop and flush all resolve on the same edge.
module digit_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 3,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Full comes from the count so a wrapped pointer pair is never ambiguous.
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; head is only consumed when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_digit_sequencer.sv
// Filters UART bytes to octal digits, queues them and shows each for a fixed hold time.
module uart_digit_sequencer
  import uart_pkg::*;
#(
  parameter  int HOLD_CYCLES = 50_000_000,
  parameter  int FIFO_DEPTH  = 4,
  localparam int CW          = $clog2(FIFO_DEPTH + 1),
  localparam int TW          = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [2:0]    digit_bcd,
  output logic          digit_active,
  output logic          bad_char,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);

  seq_state_e  state_q, state_d;
  char_class_e cls;
  logic [TW-1:0] timer_q;
  logic [2:0]  fifo_head;
  logic        fifo_full, fifo_nonempty;
  logic        accept, clr, push, pop, timer_done;

  assign cls           = classify(rx_data);
  assign rx_ready      = !fifo_full;
  assign accept        = rx_valid && rx_ready;
  assign clr           = accept && (cls == CLS_CLEAR);
  assign push          = accept && (cls == CLS_DIGIT);
  assign fifo_nonempty = (fifo_count != '0);
  assign timer_done    = (timer_q == '0);
  // Clear beats any pop; IDLE pops immediately, SHOW pops only on expiry.
  assign pop           = !clr && fifo_nonempty && ((state_q == IDLE) || timer_done);

  digit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (rx_data[2:0]),
    .pop   (pop),
    .flush (clr),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: leave SHOW only when the hold expires with nothing queued.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (fifo_nonempty) state_d = SHOW;
        SHOW:    if (timer_done && !fifo_nonempty) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore output: the display is live for the whole of SHOW.
  always_comb begin
    digit_active = (state_q == SHOW);
  end

  // Hold timer: reload on every pop, count down while showing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             timer_q <= '0;
    else if (clr)                           timer_q <= '0;
    else if (pop)                           timer_q <= TW'(HOLD_CYCLES - 1);
    else if (state_q == SHOW && !timer_done) timer_q <= timer_q - TW'(1);
  end

  // Displayed digit keeps its value through IDLE until the next pop or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   digit_bcd <= '0;
    else if (clr) digit_bcd <= '0;
    else if (pop) digit_bcd <= fifo_head;
  end

  // Status flags: one-cycle reject pulse and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_char <= 1'b0;
      overflow <= 1'b0;
    end else begin
      bad_char <= accept && (cls == CLS_BAD);
      if (clr)                       overflow <= 1'b0;
      else if (rx_valid && !rx_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_digit_sequencer.sv
// Scoreboarded bench: stimulus queues expected digits, a monitor checks each hold window.
module tb_uart_digit_sequencer;

  localparam int HOLD = 4;

  logic       clk, rst_n;
  logic [7:0] rx_data;
  logic       rx_valid, rv_s;

  logic       rx_ready, digit_active, bad_char, overflow;
  logic [2:0] digit_bcd, fifo_count;
  logic       rx_ready_s, digit_active_s, bad_char_s, overflow_s;
  logic [2:0] digit_bcd_s, fifo_count_s;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int run_len = 0, cont = 0, last_run = 0, cur = -1, peak = 0;
  int bad_cycles = 0, bad_pulses = 0;
  bit bad_prev = 0;

  uart_digit_sequencer #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .digit_bcd(digit_bcd), .digit_active(digit_active),
    .bad_char(bad_char), .overflow(overflow), .fifo_count(fifo_count)
  );

  uart_digit_sequencer #(.HOLD_CYCLES(100), .FIFO_DEPTH(4)) u_slow (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rv_s),
    .rx_ready(rx_ready_s), .digit_bcd(digit_bcd_s), .digit_active(digit_active_s),
    .bad_char(bad_char_s), .overflow(overflow_s), .fifo_count(fifo_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offer a byte to the fast DUT, waiting a bounded time for rx_ready.
  task automatic send(input logic [7:0] b);
    bit acc;
    acc = 0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic send_digit(input int d);
    exp_q.push_back(d);
    send(8'h30 + 8'(d));
  endtask

  task automatic send_slow(input logic [7:0] b);
    rx_data = b;
    rv_s = 1'b1;
    @(posedge clk); #1;
    rv_s = 1'b0;
  endtask

  // Monitor: each HOLD-long active window must carry the next expected digit.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
      cont = 0;
      bad_prev = 0;
    end else begin
      if (digit_active) begin
        if (run_len == 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_digit", int'(digit_bcd), -1);
            cur = -1;
          end else begin
            cur = exp_q.pop_front();
          end
        end
        chk("digit_value", int'(digit_bcd), cur);
        run_len++;
        if (run_len == HOLD) run_len = 0;
        cont++;
      end else begin
        if (run_len != 0) chk("hold_len", run_len, HOLD);
        run_len = 0;
        if (cont != 0) last_run = cont;
        cont = 0;
      end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (bad_char) bad_cycles++;
      if (bad_char && !bad_prev) bad_pulses++;
      bad_prev = bad_char;
    end
  end

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rv_s = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_bcd", digit_bcd, 0);
    chk("rst_active", digit_active, 0);
    chk("rst_ready", rx_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_bad", bad_char, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_slow_ready", rx_ready_s, 1);

    // Single digit latency and hold
    send_digit(5);
    chk("lat_count", fifo_count, 1);
    chk("lat_inactive", digit_active, 0);
    @(posedge clk); #1;
    chk("lat_active", digit_active, 1);
    chk("lat_bcd", digit_bcd, 5);
    repeat (5) @(posedge clk); #1;
    chk("post_inactive", digit_active, 0);
    chk("post_bcd_held", digit_bcd, 5);

    // Back-to-back burst: continuous display, push+pop in the same cycle
    peak = 0; last_run = 0;
    send_digit(1); send_digit(2); send_digit(3);
    repeat (16) @(posedge clk); #1;
    chk("burst_run", last_run, 12);
    chk("burst_peak", peak, 2);

    // Rejects: two bad pulses, line ending silent, nothing queued
    bad_cycles = 0; bad_pulses = 0;
    send(8'h38); @(posedge clk); #1;
    send(8'h41); @(posedge clk); #1;
    send(8'h0D); repeat (2) @(posedge clk); #1;
    chk("bad_cycles", bad_cycles, 2);
    chk("bad_pulses", bad_pulses, 2);
    chk("bad_count", fifo_count, 0);
    chk("bad_bcd", digit_bcd, 3);
    chk("bad_active", digit_active, 0);

    // Pointer wrap with four more digits
    last_run = 0;
    send_digit(6); send_digit(7); send_digit(0); send_digit(2);
    repeat (20) @(posedge clk); #1;
    chk("wrap_run", last_run, 16);
    chk("wrap_bcd", digit_bcd, 2);

    // Slow instance: fill, stall, overflow
    for (int i = 1; i <= 5; i++) send_slow(8'h30 + 8'(i));
    chk("fill_ready", rx_ready_s, 0);
    chk("fill_count", fifo_count_s, 4);
    chk("fill_active", digit_active_s, 1);
    chk("fill_bcd", digit_bcd_s, 1);
    chk("fill_ovf_clear", overflow_s, 0);
    send_slow(8'h36);
    chk("ovf_set", overflow_s, 1);
    chk("ovf_count", fifo_count_s, 4);

    for (int i = 0; i < 200 && fifo_count_s != 3'd3; i++) @(posedge clk);
    #1;
    chk("drain_count", fifo_count_s, 3);
    chk("drain_bcd", digit_bcd_s, 2);
    chk("drain_ovf_sticky", overflow_s, 1);

    // Clear while showing with three queued
    send_slow(8'h63);
    chk("clr_count", fifo_count_s, 0);
    chk("clr_bcd", digit_bcd_s, 0);
    chk("clr_active", digit_active_s, 0);
    chk("clr_ovf", overflow_s, 0);
    chk("clr_ready", rx_ready_s, 1);

    // Asynchronous reset mid-SHOW
    send_slow(8'h34);
    send_slow(8'h36);
    @(posedge clk); #1;
    chk("pre_rst_active", digit_active_s, 1);
    chk("pre_rst_bcd", digit_bcd_s, 4);
    chk("pre_rst_count", fifo_count_s, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_active", digit_active_s, 0);
    chk("arst_bcd", digit_bcd_s, 0);
    chk("arst_count", fifo_count_s, 0);
    chk("arst_ready", rx_ready_s, 1);
    chk("arst_fast_bcd", digit_bcd, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
